// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package loader_pkg;

  typedef enum logic [1:0] {
    LEN  = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD = 4;

  // A length header is legal when it names at least one word and fits in memory.
  function automatic logic len_ok(input logic [31:0] n, input int addr_width);
    logic [32:0] depth_v;
    depth_v = 33'd1 << addr_width;
    return (n != 32'd0) && ({1'b0, n} <= depth_v);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Assembles accepted stream bytes into little-endian 32-bit words; word_done
// pulses combinationally on the accept of the final byte of each word.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_r;
  logic [23:0] shreg_r;

  // Byte counter and shift register; older bytes drift toward bit 0.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_r   <= 2'd0;
      shreg_r <= 24'd0;
    end else if (accept) begin
      shreg_r <= {byte_in, shreg_r[23:8]};
      cnt_r   <= cnt_r + 2'd1;
    end
  end

  assign word      = {byte_in, shreg_r};
  assign word_done = accept && (cnt_r == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes instruction words
// sequentially from address 0 and releases the CPU reset once loading is complete.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wd,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] WCNT_ONE = CW'(1);

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    ready_s;
  logic                    accept_s;
  logic                    word_done_s;
  logic [31:0]             word_s;
  logic [CW-1:0]           wcnt_r;
  logic [CW-1:0]           len_r;
  logic                    imem_we_r;
  logic [ADDR_WIDTH-1:0]   imem_addr_r;
  logic [31:0]             imem_wd_r;
  logic                    cpu_reset_r;
  logic                    done_r;
  logic                    error_r;

  assign ready_s    = ((state_r == LEN) || (state_r == DATA)) && !reset;
  assign accept_s   = byte_valid && ready_s;
  assign byte_ready = ready_s;

  word_assembler u_asm (
    .clk       (clk),
    .clear     (reset),
    .accept    (accept_s),
    .byte_in   (byte_in),
    .word      (word_s),
    .word_done (word_done_s)
  );

  // Next-state logic; DATA is left only after the final write is on the port.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      LEN: begin
        if (word_done_s) begin
          if (len_ok(word_s, ADDR_WIDTH)) begin
            state_next_s = DATA;
          end else begin
            state_next_s = ERR;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      DATA: begin
        if (imem_we_r && (wcnt_r == len_r)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = state_r;
        end
      end
      DONE:    state_next_s = DONE;
      ERR:     state_next_s = ERR;
      default: state_next_s = LEN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= LEN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Word counter, latched length and registered memory/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_r      <= '0;
      len_r       <= '0;
      imem_we_r   <= 1'b0;
      imem_addr_r <= '0;
      imem_wd_r   <= 32'd0;
      cpu_reset_r <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      imem_we_r <= 1'b0;
      if ((state_r == LEN) && word_done_s) begin
        len_r <= word_s[CW-1:0];
      end
      if ((state_r == DATA) && word_done_s) begin
        imem_we_r   <= 1'b1;
        imem_addr_r <= wcnt_r[ADDR_WIDTH-1:0];
        imem_wd_r   <= word_s;
        wcnt_r      <= wcnt_r + WCNT_ONE;
      end
      cpu_reset_r <= (state_next_s != DONE);
      done_r      <= (state_next_s == DONE);
      error_r     <= (state_next_s == ERR);
    end
  end

  assign imem_we   = imem_we_r;
  assign imem_addr = imem_addr_r;
  assign imem_wd   = imem_wd_r;
  assign cpu_reset = cpu_reset_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule
